// File: rtl/mem_map_pkg.sv
// Memory-map constants shared by the data-memory responder and its console FIFO.
package mem_map_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;
    localparam int          CON_DEPTH_DEFAULT = 4;

    // Byte offsets of the registers inside the 16-byte MMIO window
    localparam logic [3:0] OFF_CYCLE    = 4'h0;
    localparam logic [3:0] OFF_CON_DATA = 4'h4;
    localparam logic [3:0] OFF_STATUS   = 4'h8;
    localparam logic [3:0] OFF_SCRATCH  = 4'hC;

    // STATUS register bit positions; count field starts at STAT_COUNT_LSB
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_COUNT_LSB = 3;

    // Register select, taken from the word-offset bits of the address
    typedef enum logic [1:0] {
        REG_CYCLE    = OFF_CYCLE[3:2],
        REG_CON_DATA = OFF_CON_DATA[3:2],
        REG_STATUS   = OFF_STATUS[3:2],
        REG_SCRATCH  = OFF_SCRATCH[3:2]
    } mmioReg_e;

    // Replace only the byte lanes whose enable bit is set
    function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  laneEn);
        logic [31:0] res;
        res = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (laneEn[i]) res[8*i +: 8] = newWord[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous FIFO for console output bytes. A pop is honoured only when
// non-empty; a push into a full FIFO succeeds only if a pop frees a slot
// on the same edge.
module console_fifo
    import mem_map_pkg::*;
#(
    parameter  int DEPTH = CON_DEPTH_DEFAULT,
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr;
    logic [PW-1:0]    rdPtr;
    logic             doPush;
    logic             doPop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign doPop   = pop && !empty;
    assign doPush  = push && (!full || doPop);
    assign popData = empty ? '0 : mem[rdPtr];

    // Pointer and occupancy tracking; pointers wrap on their natural width
    always_ff @(posedge clk) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(doPush) - CW'(doPop);
        end
    end

    // Storage is not cleared; emptiness alone masks stale entries
    always_ff @(posedge clk) begin
        if (reset && doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: combinational-read RAM with byte-lane writes plus a
// 16-byte MMIO window (cycle counter, console FIFO, status, scratch).
module dmem_responder
    import mem_map_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEFAULT,
    parameter int          CON_DEPTH   = CON_DEPTH_DEFAULT
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [3:0]  byte_en,
    output logic [31:0] rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(CON_DEPTH) + 1;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [31:0]   cycleCnt;
    logic [31:0]   scratch;
    logic          overflow;

    logic          isMmio;
    mmioReg_e      regSel;
    logic [AW-1:0] wordIdx;
    logic          wrEn;
    logic          conPush;
    logic          conPop;
    logic          conFull;
    logic          conEmpty;
    logic [CW-1:0] conCount;
    logic          setOvf;
    logic          clrOvf;
    logic [31:0]   statusWord;
    logic          unusedAddrLsb;

    // Sub-word extraction is the core's job, so the byte offset is dropped
    assign unusedAddrLsb = &{1'b0, addr[1:0]};

    assign isMmio  = (addr[31:4] == MMIO_BASE[31:4]);
    assign regSel  = mmioReg_e'(addr[3:2]);
    assign wordIdx = addr[AW+1:2];
    assign wrEn    = we && reset;

    assign conPush  = wrEn && isMmio && (regSel == REG_CON_DATA) && byte_en[0];
    assign tx_valid = !conEmpty;
    assign conPop   = tx_valid && tx_ready;
    assign setOvf   = conPush && conFull && !conPop;
    assign clrOvf   = wrEn && isMmio && (regSel == REG_STATUS) && byte_en[0] && wdata[2];

    console_fifo #(.DEPTH(CON_DEPTH), .WIDTH(8)) uConFifo (
        .clk      (clk),
        .reset    (reset),
        .push     (conPush),
        .pushData (wdata[7:0]),
        .pop      (conPop),
        .popData  (tx_data),
        .full     (conFull),
        .empty    (conEmpty),
        .count    (conCount)
    );

    // Assemble STATUS from pre-edge FIFO state
    always_comb begin
        statusWord                           = '0;
        statusWord[STAT_EMPTY]               = conEmpty;
        statusWord[STAT_FULL]                = conFull;
        statusWord[STAT_OVERFLOW]            = overflow;
        statusWord[STAT_COUNT_LSB +: CW]     = conCount;
    end

    // Zero-latency read mux over RAM and MMIO registers
    always_comb begin
        rdata = ram[wordIdx];
        if (isMmio) begin
            case (regSel)
                REG_CYCLE:    rdata = cycleCnt;
                REG_CON_DATA: rdata = '0;
                REG_STATUS:   rdata = statusWord;
                REG_SCRATCH:  rdata = scratch;
                default:      rdata = '0;
            endcase
        end
    end

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (wrEn && !isMmio) ram[wordIdx] <= mergeLanes(ram[wordIdx], wdata, byte_en);
    end

    // Free-running cycle counter, scratch register and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            cycleCnt <= '0;
            scratch  <= '0;
            overflow <= 1'b0;
        end else begin
            cycleCnt <= cycleCnt + 32'd1;
            if (wrEn && isMmio && (regSel == REG_SCRATCH))
                scratch <= mergeLanes(scratch, wdata, byte_en);
            if (setOvf)      overflow <= 1'b1;
            else if (clrOvf) overflow <= 1'b0;
        end
    end

endmodule
